// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : risc_pkg
// Description : Shared constants and types for the 16-bit RISC datapath.
//               Holds the channel count, select width, default word width,
//               the destination-channel enum and a select-to-onehot helper.
// Revision    : 1.0 - initial release
// ============================================================================
package risc_pkg;

  localparam int CH_NUM = 4;
  localparam int SEL_W  = 2;
  localparam int RISC_W = 16;

  typedef enum logic [SEL_W-1:0] {
    CH_RF    = 2'd0,
    CH_MEM   = 2'd1,
    CH_IO    = 2'd2,
    CH_SPARE = 2'd3
  } ch_e;

  // One-hot decode of a destination select.
  function automatic logic [CH_NUM-1:0] sel_decode(input logic [SEL_W-1:0] sel);
    logic [CH_NUM-1:0] one;
    one = {{(CH_NUM-1){1'b0}}, 1'b1};
    return one << sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/risc_demux_slot.sv
`default_nettype none
// ============================================================================
// Module      : risc_demux_slot
// Description : One-entry holding register for a single demux channel.
//               A load always wins over a drain, so a word can be drained and
//               replaced at the same edge (one word per cycle per channel).
// Ports       : clk, rst        - clock, async active-high reset
//               load, load_data - write strobe and word from the top level
//               out_ready       - consumer takes the held word
//               out_valid       - slot holds a word
//               out_data        - held word (0 after reset)
// Revision    : 1.0 - initial release
// ============================================================================
module risc_demux_slot
  import risc_pkg::*;
#(
  parameter int WIDTH = RISC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load) begin
      // Load takes priority: a simultaneous drain still leaves the slot full.
      full_d = 1'b1;
      data_d = load_data;
    end else if (full_q && out_ready) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign out_valid = full_q;
  assign out_data  = data_q;

endmodule
`default_nettype wire

// File: rtl/risc_result_demux.sv
`default_nettype none
// ============================================================================
// Module      : risc_result_demux
// Description : One-to-four result distributor. Accepts one word per cycle
//               with a 2-bit destination select and holds it in a one-entry
//               slot of the addressed channel. Each channel has its own
//               valid/ready handshake so a stalled consumer only blocks the
//               words addressed to it.
// Ports       : clk, rst                 - clock, async active-high reset
//               in_valid/in_ready        - producer handshake
//               in_data, in_sel          - result word and destination
//               out_valid[3:0]           - per-channel slot occupied
//               out_ready[3:0]           - per-channel consumer ready
//               out_data0..out_data3     - per-channel slot contents
//               accept_cnt               - words accepted since reset (wraps)
//               busy                     - any channel occupied
// Revision    : 1.0 - initial release
// ============================================================================
module risc_result_demux
  import risc_pkg::*;
#(
  parameter int WIDTH = RISC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [SEL_W-1:0]  in_sel,
  output logic [CH_NUM-1:0] out_valid,
  input  logic [CH_NUM-1:0] out_ready,
  output logic [WIDTH-1:0]  out_data0,
  output logic [WIDTH-1:0]  out_data1,
  output logic [WIDTH-1:0]  out_data2,
  output logic [WIDTH-1:0]  out_data3,
  output logic [15:0]       accept_cnt,
  output logic              busy
);

  logic              accept;
  logic [CH_NUM-1:0] load;
  logic [WIDTH-1:0]  slot_data [CH_NUM];
  logic [15:0]       accept_cnt_q, accept_cnt_d;

  // Combinational out_ready -> in_ready path; independent of in_valid.
  assign in_ready = !out_valid[in_sel] || out_ready[in_sel];
  assign accept   = in_valid && in_ready;
  assign load     = accept ? sel_decode(in_sel) : '0;

  generate
    for (genvar k = 0; k < CH_NUM; k++) begin : g_slot
      risc_demux_slot #(
        .WIDTH(WIDTH)
      ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (load[k]),
        .load_data (in_data),
        .out_ready (out_ready[k]),
        .out_valid (out_valid[k]),
        .out_data  (slot_data[k])
      );
    end
  endgenerate

  assign out_data0 = slot_data[CH_RF];
  assign out_data1 = slot_data[CH_MEM];
  assign out_data2 = slot_data[CH_IO];
  assign out_data3 = slot_data[CH_SPARE];

  // Natural 16-bit wrap from 0xFFFF to 0x0000.
  assign accept_cnt_d = accept ? accept_cnt_q + 16'd1 : accept_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accept_cnt_q <= '0;
    end else begin
      accept_cnt_q <= accept_cnt_d;
    end
  end

  assign accept_cnt = accept_cnt_q;
  assign busy       = |out_valid;

endmodule
`default_nettype wire

// File: tb/tb_risc_result_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_risc_result_demux
// Description : Self-checking bench for risc_result_demux. Stimulus pushes
//               expected words into per-channel queues on accept; a monitor
//               pops and compares whenever a channel handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_risc_result_demux;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] out_data0, out_data1, out_data2, out_data3;
  logic [15:0] accept_cnt;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [15:0] q [4][$];
  logic [15:0] od [4];

  assign od[0] = out_data0;
  assign od[1] = out_data1;
  assign od[2] = out_data2;
  assign od[3] = out_data3;

  risc_result_demux #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data0  (out_data0),
    .out_data1  (out_data1),
    .out_data2  (out_data2),
    .out_data3  (out_data3),
    .accept_cnt (accept_cnt),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a handshake seen on the falling edge completes at the next rise.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          if (q[k].size() == 0) begin
            chk($sformatf("unexpected_ch%0d", k), {16'h0, od[k]}, 32'hFFFF_FFFF);
          end else begin
            chk($sformatf("sb_ch%0d", k), {16'h0, od[k]}, {16'h0, q[k].pop_front()});
          end
        end
      end
    end
  end

  // Present a word, wait (bounded) for in_ready, then complete the accept.
  task automatic send(input logic [15:0] d, input logic [1:0] s, output int stalls);
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
    stalls   = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      stalls++;
      if (stalls > 50) begin
        chk("send_timeout", 32'(stalls), 32'd0);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    q[s].push_back(d);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int st;
    int tot;
    longint t0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    in_sel    = 2'd0;
    out_ready = 4'b0000;

    // Reset state
    #1;
    chk("rst_out_valid", {28'h0, out_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_accept_cnt", {16'h0, accept_cnt}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // in_valid low: select and data ignored
    in_data = 16'hDEAD;
    in_sel  = 2'd1;
    @(posedge clk); #1;
    chk("idle_out_valid", {28'h0, out_valid}, 32'h0);
    chk("idle_accept_cnt", {16'h0, accept_cnt}, 32'h0);

    // Basic route, back-to-back
    out_ready = 4'b1111;
    tot = 0;
    send(16'h1111, 2'd0, st); tot += st;
    chk("route0_valid", {31'h0, out_valid[0]}, 32'h1);
    chk("route0_data", {16'h0, out_data0}, 32'h1111);
    send(16'h2222, 2'd1, st); tot += st;
    chk("route1_data", {16'h0, out_data1}, 32'h2222);
    send(16'h3333, 2'd2, st); tot += st;
    chk("route2_data", {16'h0, out_data2}, 32'h3333);
    send(16'h4444, 2'd3, st); tot += st;
    chk("route3_data", {16'h0, out_data3}, 32'h4444);
    chk("route_stalls", 32'(tot), 32'd0);
    chk("route_accept_cnt", {16'h0, accept_cnt}, 32'd4);

    // Backpressure on channel 1
    out_ready = 4'b1101;
    send(16'hAAAA, 2'd1, st);
    in_valid = 1'b1;
    in_data  = 16'hBBBB;
    in_sel   = 2'd1;
    @(negedge clk);
    chk("bp_in_ready_low", {31'h0, in_ready}, 32'h0);
    chk("bp_hold_data", {16'h0, out_data1}, 32'hAAAA);
    @(posedge clk); #1;
    chk("bp_still_held", {16'h0, out_data1}, 32'hAAAA);
    out_ready = 4'b1111;
    send(16'hBBBB, 2'd1, st);
    chk("bp_pass_stalls", 32'(st), 32'd0);
    chk("bp_new_valid", {31'h0, out_valid[1]}, 32'h1);
    chk("bp_new_data", {16'h0, out_data1}, 32'hBBBB);

    // Isolation: channel 3 stalled and full
    out_ready = 4'b0111;
    send(16'h7777, 2'd3, st);
    send(16'h5A5A, 2'd0, st);
    chk("iso_stalls", 32'(st), 32'd0);
    chk("iso_ch0_data", {16'h0, out_data0}, 32'h5A5A);
    chk("iso_ch3_valid", {31'h0, out_valid[3]}, 32'h1);
    repeat (2) @(posedge clk); #1;
    chk("iso_ch3_held", {16'h0, out_data3}, 32'h7777);
    out_ready = 4'b1111;
    @(posedge clk); #1;

    // Streaming eight words through channel 2
    tot = 0;
    t0  = $time;
    for (int i = 0; i < 8; i++) begin
      send(16'hC000 + 16'(i), 2'd2, st);
      tot += st;
    end
    chk("stream_stalls", 32'(tot), 32'd0);
    chk("stream_time", 32'($time - t0), 32'd80);
    @(posedge clk); #1;

    // Asynchronous reset with channel 2 full
    out_ready = 4'b1011;
    send(16'hCCCC, 2'd2, st);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", {28'h0, out_valid}, 32'h0);
    chk("arst_out_data2", {16'h0, out_data2}, 32'h0);
    chk("arst_accept_cnt", {16'h0, accept_cnt}, 32'h0);
    q[2].delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 4'b1111;

    // Counter wrap
    for (int i = 0; i < 65535; i++) begin
      send(16'(i), 2'(i), st);
    end
    chk("wrap_ffff", {16'h0, accept_cnt}, 32'hFFFF);
    send(16'h1234, 2'd0, st);
    chk("wrap_zero", {16'h0, accept_cnt}, 32'h0);

    // Drain and confirm nothing left undelivered
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("sb_empty_ch%0d", k), 32'(q[k].size()), 32'd0);
    end
    chk("final_busy", {31'h0, busy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
